// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access size encodings,
// controller FSM states and the byte-strobe mask helper.
// Optional feature macro used by this slice: DMEM_CTRL_ALIGN_CHECK_EN.
package dmem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Unshifted byte-strobe mask for an access size; the illegal encoding 11
  // behaves as a word.
  function automatic logic [3:0] strb_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: strb_mask = 4'b0001;
      SZ_HALF: strb_mask = 4'b0011;
      default: strb_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane alignment: store strobes and lane-shifted write
// data, load extraction with sign/zero extension, and misalignment detection.
// Macro DMEM_CTRL_ALIGN_CHECK_EN: defined -> misaligned halves/words are
// flagged and suppressed; undefined -> the offset is forced into the word.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [1:0]  off;
  logic [31:0] shifted;
  logic        mis;

  // Effective lane offset and misalignment flag
  always_comb begin
    off = offset_i;
    mis = 1'b0;
`ifdef DMEM_CTRL_ALIGN_CHECK_EN
    case (size_i)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = offset_i[0];
      default: mis = |offset_i;
    endcase
`else
    case (size_i)
      SZ_BYTE: off = offset_i;
      SZ_HALF: off = {offset_i[1], 1'b0};
      default: off = 2'b00;
    endcase
`endif
  end

  // Store strobes/data and load extraction with extension
  always_comb begin
    strb_o  = mis ? 4'b0000 : (strb_mask(size_i) << off);
    wdata_o = wdata_i << {off, 3'b000};
    shifted = mem_rdata_i >> {off, 3'b000};
    case (size_i)
      SZ_BYTE: rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
    if (mis) rdata_o = '0;
    misalign_o = mis;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port data-memory controller: round-robin arbitration between the
// load/store port (p0) and the loader port (p1), one access per two cycles,
// registered responses two cycles after grant.
// Macro DMEM_CTRL_ALIGN_CHECK_EN enables misaligned-access error reporting.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic              p0_unsigned,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rsp_valid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic              p1_unsigned,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rsp_valid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_we,
  input  logic [31:0]       mem_dout
);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          rsp_valid_q;
  logic [1:0][31:0]    rdata_q;
  logic [1:0]          err_q;

  logic                sel;
  logic                in_access;
  logic [31:0]         addr32;
  logic [3:0]          lane_strb;
  logic [31:0]         lane_wdata;
  logic [31:0]         lane_rdata;
  logic                lane_mis;

  assign in_access = (state_q == ST_ACCESS);
  assign addr32    = 32'(addr_q);

  dmem_lane_align u_lane (
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .offset_i    (addr32[1:0]),
    .wdata_i     (wdata_q),
    .mem_rdata_i (mem_dout),
    .strb_o      (lane_strb),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata),
    .misalign_o  (lane_mis)
  );

  // Arbitration, request latching and next-state selection
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel     = 1'b0;
    p0_gnt  = 1'b0;
    p1_gnt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && (p0_req || p1_req)) begin
          // On a tie the port that did not win last time goes next
          sel     = (p0_req && p1_req) ? ~last_q : p1_req;
          p0_gnt  = ~sel;
          p1_gnt  = sel;
          last_d  = sel;
          port_d  = sel;
          we_d    = sel ? p1_we       : p0_we;
          size_d  = sel ? p1_size     : p0_size;
          uns_d   = sel ? p1_unsigned : p0_unsigned;
          addr_d  = sel ? p1_addr     : p0_addr;
          wdata_d = sel ? p1_wdata    : p0_wdata;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_IDLE;
    endcase
  end

  // Memory-side drive; strobes gated by reset so an abandoned access never writes
  always_comb begin
    mem_addr = in_access ? {addr32[31:2], 2'b00} : '0;
    mem_din  = in_access ? lane_wdata : '0;
    mem_we   = (in_access && rst_n && we_q) ? lane_strb : '0;
  end

  // State, latched request and registered per-port responses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      port_q      <= port_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= '0;
      if (in_access) begin
        rsp_valid_q[port_q] <= 1'b1;
        rdata_q[port_q]     <= we_q ? '0 : lane_rdata;
        err_q[port_q]       <= lane_mis;
      end
    end
  end

  assign p0_rsp_valid = rsp_valid_q[0];
  assign p1_rsp_valid = rsp_valid_q[1];
  assign p0_rdata     = rdata_q[0];
  assign p1_rdata     = rdata_q[1];
  assign p0_err       = err_q[0];
  assign p1_err       = err_q[1];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl with a behavioural byte-writable memory.
// Expectations for misaligned cases follow DMEM_CTRL_ALIGN_CHECK_EN.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p0_unsigned;
  logic [1:0]  p0_size;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_gnt, p0_rsp_valid, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we, p1_unsigned;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_rsp_valid, p1_err;
  logic [31:0] p1_rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [3:0]  mem_we;

  logic [31:0] mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
    .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
    .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  // Memory model: combinational read, byte writes at the clock edge
  assign mem_dout = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_din[8*b +: 8];
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_we;
    logic        chk_din;
    logic [31:0] exp_din;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_port(input logic port, input logic req, input logic we,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (!port) begin
      p0_req = req; p0_we = we; p0_size = size; p0_unsigned = uns;
      p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_size = size; p1_unsigned = uns;
      p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // Entered at posedge+1 in an idle cycle; leaves in the response cycle
  task automatic run_vec(input vec_t v);
    int n;
    logic g;
    set_port(v.port, 1'b1, v.we, v.size, v.uns, v.addr, v.wdata);
    #1;
    n = 0;
    g = v.port ? p1_gnt : p0_gnt;
    while (!g && n < 20) begin
      @(posedge clk); #1;
      n++;
      g = v.port ? p1_gnt : p0_gnt;
    end
    check("gnt", {31'd0, g}, 32'd1);
    check("gnt_other", {31'd0, v.port ? p0_gnt : p1_gnt}, 32'd0);
    @(posedge clk); #1;
    if (!v.port) p0_req = 1'b0; else p1_req = 1'b0;
    check("mem_we", {28'd0, mem_we}, {28'd0, v.exp_we});
    check("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
    if (v.chk_din) check("mem_din", mem_din, v.exp_din);
    @(posedge clk); #1;
    check("rsp_valid", {31'd0, v.port ? p1_rsp_valid : p0_rsp_valid}, 32'd1);
    check("rsp_other", {31'd0, v.port ? p0_rsp_valid : p1_rsp_valid}, 32'd0);
    check("rdata", v.port ? p1_rdata : p0_rdata, v.exp_rdata);
    check("err", {31'd0, v.port ? p1_err : p0_err}, {31'd0, v.exp_err});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[8] = 32'h11223344;

    //            port we  size  uns addr   wdata         exp_we  din   exp_din       exp_rdata     err
    vecs[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        4'b0000, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h80,       4'b1000, 1'b1, 32'h80000000, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        4'b0000, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hA5A5,     4'b1100, 1'b1, 32'hA5A50000, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        4'b0000, 1'b0, 32'h0,        32'hFFFFA5A5, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        4'b0000, 1'b0, 32'h0,        32'hA5A53344, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h00003344, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        4'b0000, 1'b0, 32'h0,        32'hFFFFFFBE, 1'b0};
`ifdef DMEM_CTRL_ALIGN_CHECK_EN
    vecs[10] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 4'b0000, 1'b0, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h07, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        1'b1};
`else
    vecs[10] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 4'b1111, 1'b1, 32'h12345678, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h12345678, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h07, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h00001234, 1'b0};
`endif
    vecs[13] = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'hCAFEF00D, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0,        4'b0000, 1'b0, 32'h0,        32'hFFFFCAFE, 1'b0};

    rst_n = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    // A request during reset must not be granted
    p0_req = 1'b1;
    #1;
    check("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    check("rst_rsp", {30'd0, p0_rsp_valid, p1_rsp_valid}, 32'd0);
    check("rst_rdata0", p0_rdata, 32'h0);
    check("rst_rdata1", p1_rdata, 32'h0);
    check("rst_err", {30'd0, p0_err, p1_err}, 32'd0);
    check("rst_mem_we", {28'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_din", mem_din, 32'h0);
    p0_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);
`ifdef DMEM_CTRL_ALIGN_CHECK_EN
    check("mem_04_unchanged", mem[1], 32'h0);
`else
    check("mem_04_written", mem[1], 32'h12345678);
`endif

    // Reset asserted in the access cycle of a store
    set_port(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h55555555);
    #1;
    n = 0;
    while (!p0_gnt && n < 20) begin @(posedge clk); #1; n++; end
    check("rstacc_gnt", {31'd0, p0_gnt}, 32'd1);
    @(posedge clk); #1;
    p0_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rstacc_mem_we", {28'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    check("rstacc_rsp", {30'd0, p0_rsp_valid, p1_rsp_valid}, 32'd0);
    check("rstacc_rdata1", p1_rdata, 32'h0);
    check("rstacc_err", {30'd0, p0_err, p1_err}, 32'd0);
    check("rstacc_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    check("rstacc_mem", mem[16], 32'h0);
    check("rstacc_rsp2", {30'd0, p0_rsp_valid, p1_rsp_valid}, 32'd0);

    // Release with both ports requesting continuously: p0 wins the first tie
    rst_n = 1'b1;
    set_port(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    #1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("rr_p0_gnt_c%0d", c), {31'd0, p0_gnt}, {31'd0, (c % 4) == 0});
      check($sformatf("rr_p1_gnt_c%0d", c), {31'd0, p1_gnt}, {31'd0, (c % 4) == 2});
      check($sformatf("rr_p0_rsp_c%0d", c), {31'd0, p0_rsp_valid}, {31'd0, (c % 4) == 2});
      check($sformatf("rr_p1_rsp_c%0d", c), {31'd0, p1_rsp_valid}, {31'd0, c >= 4 && (c % 4) == 0});
      if (c == 2) check("rr_p0_rdata", p0_rdata, 32'h80ADBEEF);
      if (c == 4) check("rr_p1_rdata", p1_rdata, 32'hA5A53344);
      @(posedge clk); #1;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Two-port data-memory controller that shares the single-port, byte-writable data memory between the CPU load/store port (port 0) and the DMA/program-loader port (port 1). It arbitrates round-robin, converts byte/half/word accesses into word addresses, byte write strobes and shifted write data, and returns aligned, sign- or zero-extended read data on a registered response. It sits between the core's load/store stage and loader on one side and the data memory on the other, and it is the only driver of the memory's address, write-data and write-enable inputs.

## Interface
- `ADDR_W`, default 32: request address width.
- `p0_*` / `p1_*` ports below exist per requester; `pN` means either port.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, **synchronous, active-low**.
- `pN_req` input, 1: request valid; held until `pN_gnt`.
- `pN_we` input, 1: 1 = store, 0 = load.
- `pN_size` input, 2: 00 byte, 01 half, 10 word; 11 is illegal and treated as word.
- `pN_unsigned` input, 1: zero-extend loads (1) or sign-extend (0).
- `pN_addr` input, ADDR_W: byte address.
- `pN_wdata` input, 32: store data, right-justified.
- `pN_gnt` output, 1: request accepted this cycle.
- `pN_rsp_valid` output, 1: one-cycle pulse; response ready.
- `pN_rdata` output, 32: load result, valid only with `pN_rsp_valid`; 0 for stores.
- `pN_err` output, 1: qualifies `pN_rsp_valid`; misaligned access (see Configuration).
- `mem_addr` output, 32: word address to memory, bits [1:0] forced to 0.
- `mem_din` output, 32: lane-shifted write data.
- `mem_we` output, 4: byte write strobes.
- `mem_dout` input, 32: combinational read data from memory.

## Operation
- FSM states: IDLE and ACCESS. Reset state: IDLE.
- IDLE: if any `pN_req` is high, pick the winner, assert its `pN_gnt` for that cycle, latch `we`, `size`, `unsigned`, `addr`, `wdata` and the port id, then go to ACCESS. With no request, stay in IDLE.
- Arbitration: round-robin on the `last` register. When both ports request, grant the port not equal to `last`. With a single request, that port is granted. `last` updates on every grant and resets to 1, so port 0 wins the first tie.
- ACCESS:
  - Drive `mem_addr` = {latched addr[31:2], 2'b00}.
  - Stores: `mem_we` = size mask (byte 0001, half 0011, word 1111) shifted left by addr[1:0]; `mem_din` = wdata shifted left by 8×addr[1:0].
  - Loads: `mem_we` = 0. Select the byte or half from `mem_dout` at addr[1:0], then extend to 32 bits.
  - Register the rdata/err for the latched port, pulse its `rsp_valid` next cycle, and return to IDLE.
- Outside ACCESS: `mem_we` = 0, `mem_addr` = 0, `mem_din` = 0.
- `mem_we` is gated by `rst_n`, so no write occurs in a reset cycle.
- Reset values: all `gnt`, `rsp_valid` and `err` = 0; all `rdata` = 0; `mem_*` = 0; `last` = 1.

## Timing
- Request accepted in cycle N (`gnt` high in N).
- Memory access in cycle N+1.
- `rsp_valid` high in N+2. Load latency is 2 cycles.
- Throughput: one access per 2 cycles. A new grant may occur in cycle N+2, the same cycle as the previous response.
- `gnt` is never asserted in ACCESS. The losing requester waits with `req` held.
- Reset asserted during ACCESS: the access is abandoned, no write occurs, and no `rsp_valid` is produced.
- Store followed by a load to the same word: the load returns the stored data, because the memory writes at the end of N+1.

## Configuration
- Macro: `DMEM_CTRL_ALIGN_CHECK_EN`.
- Defined:
  - A half with addr[0]=1, or a word with addr[1:0]≠0, is misaligned.
  - Misaligned stores get `mem_we` forced to 0.
  - Misaligned loads return `rdata` = 0.
  - Both respond with `err`=1 on the normal `rsp_valid` cycle.
- Undefined:
  - `err` is tied 0.
  - Half addresses are forced to addr[1]:0 and word addresses to 00.
  - The access proceeds within the word.

## Structure
- `dmem_ctrl_pkg` holds:
  - the size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - the FSM state enum;
  - the strobe-mask function.
- Sub-module `dmem_lane_align`: purely combinational. It generates the store strobes and shifted data, and performs load extraction and extension. It is reused by the instruction-fetch path later.

## Test plan
- Port 0 stores word 0xDEADBEEF at 0x10, then loads word at 0x10 → `mem_we`=1111 in the access cycle; `p0_rdata`=0xDEADBEEF two cycles after `gnt`.
- Port 0 stores byte 0x80 at 0x13, then loads signed byte 0x13 → `mem_we`=1000, `mem_din`=0x80000000; `rdata`=0xFFFFFF80. Loading unsigned returns 0x00000080.
- Store half 0xA5A5 at 0x22, then load signed half 0x22 → `mem_we`=1100; `rdata`=0xFFFFA5A5. The word at 0x20 keeps its low half unchanged.
- Both ports request continuously → grants alternate p0, p1, p0, … four cycles apart per port; each `rsp_valid` goes only to the granted port.
- With the macro defined, a word store to 0x06 → `mem_we`=0, `p1_err`=1 with `rsp_valid`, and memory is unchanged. With the macro undefined, the store writes word 0x04 and `err`=0.
- `rst_n` low during ACCESS of a store → no memory change, no `rsp_valid`, outputs at reset values, and after release a tie is granted to port 0.
